// File: rtl/scan_pkg.sv
// Shared definitions for the scan multiplexer: width derivations and mode encoding.
package scan_pkg;

    // Operating mode as seen on the auto input.
    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_e;

    // Ceiling log2 with a floor of one bit, so single-value counters still get a bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((w < 32) && ((32'd1 << w) < n)) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Width of the dwell counter, which must represent 0..DWELL-1.
    function automatic int unsigned dcnt_width(input int unsigned dwell);
        return clog2_min1(dwell + 1);
    endfunction

endpackage

// File: rtl/scan_ctr.sv
// Scan pointer and dwell counter for auto mode.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   en        - advance the counters this cycle (enabled auto-mode cycle)
//   restart   - treat the pointer and dwell count as zero before advancing
//   ptr       - registered scan pointer (0..CH-1)
//   wrap      - registered one-cycle pulse when ptr wraps from CH-1 to 0
module scan_ctr
    import scan_pkg::*;
#(
    parameter  int unsigned CH    = 8,
    parameter  int unsigned DWELL = 1,
    localparam int unsigned SW    = clog2_min1(CH),
    localparam int unsigned DCW   = dcnt_width(DWELL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          restart,
    output logic [SW-1:0] ptr,
    output logic          wrap
);

    logic [SW-1:0]  ptr_q,  ptr_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic           wrap_q, wrap_d;
    logic [SW-1:0]  ptr_cur;
    logic [DCW-1:0] dcnt_cur;

    // Next-state: a restart zeroes the counters before this cycle's step.
    always_comb begin
        ptr_d    = ptr_q;
        dcnt_d   = dcnt_q;
        wrap_d   = 1'b0;
        ptr_cur  = restart ? '0 : ptr_q;
        dcnt_cur = restart ? '0 : dcnt_q;
        if (en) begin
            if (dcnt_cur == DCW'(DWELL - 1)) begin
                dcnt_d = '0;
                if (ptr_cur == SW'(CH - 1)) begin
                    ptr_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    ptr_d = ptr_cur + SW'(1);
                end
            end else begin
                dcnt_d = dcnt_cur + DCW'(1);
                ptr_d  = ptr_cur;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            dcnt_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            dcnt_q <= dcnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign ptr  = ptr_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/scan_mux.sv
// Registered N:1 channel multiplexer with manual select and auto-scan modes.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   i        - CH packed channels of DW bits, channel k at i[k*DW +: DW]
//   s        - manual channel select (ignored in auto mode)
//   auto     - 1 = auto-scan, 0 = manual
//   en       - sampling enable; 0 freezes data, index and scan position
//   y        - registered selected data
//   y_ch     - channel index y came from
//   y_vld    - y / y_ch updated by a valid selection this cycle
//   wrap     - one-cycle pulse with the last output of channel CH-1 in a scan
module scan_mux
    import scan_pkg::*;
#(
    parameter  int unsigned CH    = 8,
    parameter  int unsigned DW    = 4,
    parameter  int unsigned DWELL = 1,
    localparam int unsigned SW    = clog2_min1(CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH*DW-1:0] i,
    input  logic [SW-1:0]    s,
    input  logic             auto,
    input  logic             en,
    output logic [DW-1:0]    y,
    output logic [SW-1:0]    y_ch,
    output logic             y_vld,
    output logic             wrap
);

    logic [DW-1:0] y_q,     y_d;
    logic [SW-1:0] y_ch_q,  y_ch_d;
    logic          y_vld_q, y_vld_d;
    logic          auto_q_q, auto_q_d;

    logic          is_auto;
    logic          entry;
    logic [SW-1:0] ptr;
    logic [SW-1:0] idx;
    logic          idx_ok;
    logic [DW-1:0] pick;

    assign is_auto = (mode_e'(auto) == MODE_AUTO);

    // Mode entry is an enabled cycle with auto high after a non-auto enabled cycle.
    assign entry = en && is_auto && !auto_q_q;

    scan_ctr #(
        .CH    (CH),
        .DWELL (DWELL)
    ) u_ctr (
        .clk     (clk),
        .rst     (rst),
        .en      (en && is_auto),
        .restart (entry),
        .ptr     (ptr),
        .wrap    (wrap)
    );

    // Channel index for this cycle; on entry the scan starts from channel 0.
    always_comb begin
        idx    = s;
        idx_ok = (32'(s) < CH);
        if (is_auto) begin
            idx    = entry ? '0 : ptr;
            idx_ok = 1'b1;
        end
    end

    // Channel slice; indices at or above CH fall through to zero.
    always_comb begin
        pick = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            if (idx == SW'(k)) begin
                pick = i[k*DW +: DW];
            end
        end
    end

    // Output register next-state; invalid selects hold data and flag not-valid.
    always_comb begin
        y_d      = y_q;
        y_ch_d   = y_ch_q;
        y_vld_d  = 1'b0;
        auto_q_d = auto_q_q;
        if (en) begin
            auto_q_d = auto;
            if (idx_ok) begin
                y_d     = pick;
                y_ch_d  = idx;
                y_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q      <= '0;
            y_ch_q   <= '0;
            y_vld_q  <= 1'b0;
            auto_q_q <= 1'b0;
        end else begin
            y_q      <= y_d;
            y_ch_q   <= y_ch_d;
            y_vld_q  <= y_vld_d;
            auto_q_q <= auto_q_d;
        end
    end

    assign y     = y_q;
    assign y_ch  = y_ch_q;
    assign y_vld = y_vld_q;

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: three configurations (8ch/dwell1, 6ch/dwell2, 4ch/dwell3)
// checked against a cycle-level behavioural model of the mux rules.
module tb_scan_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: CH=8, DW=4, DWELL=1
    logic        a_rst, a_en, a_auto;
    logic [2:0]  a_s;
    logic [31:0] a_i;
    logic [3:0]  a_y;
    logic [2:0]  a_ych;
    logic        a_vld, a_wrap;

    // Instance B: CH=6, DW=4, DWELL=2
    logic        b_rst, b_en, b_auto;
    logic [2:0]  b_s;
    logic [23:0] b_i;
    logic [3:0]  b_y;
    logic [2:0]  b_ych;
    logic        b_vld, b_wrap;

    // Instance C: CH=4, DW=4, DWELL=3
    logic        c_rst, c_en, c_auto;
    logic [1:0]  c_s;
    logic [15:0] c_i;
    logic [3:0]  c_y;
    logic [1:0]  c_ych;
    logic        c_vld, c_wrap;

    scan_mux #(.CH(8), .DW(4), .DWELL(1)) u_a (
        .clk(clk), .rst(a_rst), .i(a_i), .s(a_s), .auto(a_auto), .en(a_en),
        .y(a_y), .y_ch(a_ych), .y_vld(a_vld), .wrap(a_wrap)
    );
    scan_mux #(.CH(6), .DW(4), .DWELL(2)) u_b (
        .clk(clk), .rst(b_rst), .i(b_i), .s(b_s), .auto(b_auto), .en(b_en),
        .y(b_y), .y_ch(b_ych), .y_vld(b_vld), .wrap(b_wrap)
    );
    scan_mux #(.CH(4), .DW(4), .DWELL(3)) u_c (
        .clk(clk), .rst(c_rst), .i(c_i), .s(c_s), .auto(c_auto), .en(c_en),
        .y(c_y), .y_ch(c_ych), .y_vld(c_vld), .wrap(c_wrap)
    );

    // Reference model state: k counts enabled auto cycles since mode entry.
    int       m_k    [3];
    bit       m_prev [3];
    logic [3:0] e_y  [3];
    int       e_ch   [3];
    bit       e_vld  [3];
    bit       e_wrap [3];

    task automatic model_step(input int id, input int chn, input int dw,
                              input logic rst, input logic en, input logic auto,
                              input int s, input logic [63:0] iv);
        int ch;
        if (rst) begin
            e_y[id] = 4'h0; e_ch[id] = 0; e_vld[id] = 1'b0; e_wrap[id] = 1'b0;
            m_k[id] = 0; m_prev[id] = 1'b0;
        end else if (!en) begin
            e_vld[id] = 1'b0; e_wrap[id] = 1'b0;
        end else if (auto) begin
            if (!m_prev[id]) m_k[id] = 0;
            ch = (m_k[id] / dw) % chn;
            e_y[id]    = iv[ch*4 +: 4];
            e_ch[id]   = ch;
            e_vld[id]  = 1'b1;
            e_wrap[id] = ((m_k[id] % (chn*dw)) == chn*dw - 1);
            m_k[id]    = m_k[id] + 1;
            m_prev[id] = 1'b1;
        end else begin
            m_prev[id] = 1'b0;
            e_wrap[id] = 1'b0;
            if (s < chn) begin
                e_y[id] = iv[s*4 +: 4]; e_ch[id] = s; e_vld[id] = 1'b1;
            end else begin
                e_vld[id] = 1'b0;
            end
        end
    endtask

    // Advance every model on the current inputs, clock once, land on the falling edge.
    task automatic tick();
        model_step(0, 8, 1, a_rst, a_en, a_auto, int'(a_s), 64'(a_i));
        model_step(1, 6, 2, b_rst, b_en, b_auto, int'(b_s), 64'(b_i));
        model_step(2, 4, 3, c_rst, c_en, c_auto, int'(c_s), 64'(c_i));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        a_rst = 1; b_rst = 1; c_rst = 1;
        a_auto = 1; b_auto = 1; c_auto = 1;
        a_en = 1; b_en = 1; c_en = 1;
        for (int n = 0; n < 2; n++) begin
            a_i = $urandom; b_i = 24'($urandom); c_i = 16'($urandom);
            a_s = 3'($urandom); b_s = 3'($urandom); c_s = 2'($urandom);
            tick();
            checks++;
            if ({a_y, a_ych, a_vld, a_wrap} !== 9'h0) begin
                failures++; $display("FAIL reset_a act=%h exp=0", {a_y, a_ych, a_vld, a_wrap});
            end
            checks++;
            if ({b_y, b_ych, b_vld, b_wrap} !== 9'h0) begin
                failures++; $display("FAIL reset_b act=%h exp=0", {b_y, b_ych, b_vld, b_wrap});
            end
            checks++;
            if ({c_y, c_ych, c_vld, c_wrap} !== 8'h0) begin
                failures++; $display("FAIL reset_c act=%h exp=0", {c_y, c_ych, c_vld, c_wrap});
            end
        end
        a_rst = 0; b_rst = 0; c_rst = 0;
        a_auto = 0; b_auto = 0; c_auto = 0;
    endtask

    task automatic test_manual();
        a_i = 32'h7654_3210; a_s = 3'd5; a_auto = 0; a_en = 1;
        tick();
        checks++;
        if ({a_y, a_ych, a_vld} !== {4'h5, 3'd5, 1'b1}) begin
            failures++; $display("FAIL manual_sel5 act=%h exp=%h", {a_y, a_ych, a_vld}, {4'h5, 3'd5, 1'b1});
        end
        for (int n = 0; n < 16; n++) begin
            a_i = $urandom; a_s = 3'($urandom); a_en = ($urandom_range(0, 3) != 0);
            tick();
            checks++;
            if ({a_y, a_ych, a_vld, a_wrap} !== {e_y[0], 3'(e_ch[0]), e_vld[0], e_wrap[0]}) begin
                failures++;
                $display("FAIL manual_rand act=%h exp=%h", {a_y, a_ych, a_vld, a_wrap},
                         {e_y[0], 3'(e_ch[0]), e_vld[0], e_wrap[0]});
            end
        end
        a_en = 1;
    endtask

    task automatic test_out_of_range();
        logic [3:0] hy;
        b_auto = 0; b_en = 1; b_s = 3'd2; b_i = 24'($urandom);
        hy = b_i[11:8];
        tick();
        checks++;
        if ({b_y, b_ych, b_vld} !== {hy, 3'd2, 1'b1}) begin
            failures++; $display("FAIL oor_setup act=%h exp=%h", {b_y, b_ych, b_vld}, {hy, 3'd2, 1'b1});
        end
        for (int n = 6; n < 8; n++) begin
            b_s = 3'(n); b_i = 24'($urandom);
            tick();
            checks++;
            if ({b_y, b_ych, b_vld} !== {hy, 3'd2, 1'b0}) begin
                failures++; $display("FAIL oor_sel%0d act=%h exp=%h", n, {b_y, b_ych, b_vld}, {hy, 3'd2, 1'b0});
            end
        end
    endtask

    task automatic test_auto_scan();
        int wraps = 0;
        int ech;
        c_i = 16'hDCBA; c_auto = 1; c_en = 1;
        for (int k = 0; k < 24; k++) begin
            tick();
            ech = (k / 3) % 4;
            if (c_wrap) wraps++;
            checks++;
            if ({c_y, c_ych, c_vld, c_wrap} !== {4'(4'hA + ech), 2'(ech), 1'b1, ((k % 12) == 11)}) begin
                failures++;
                $display("FAIL auto_scan k=%0d act=%h exp=%h", k, {c_y, c_ych, c_vld, c_wrap},
                         {4'(4'hA + ech), 2'(ech), 1'b1, ((k % 12) == 11)});
            end
        end
        checks++;
        if (wraps !== 2) begin
            failures++; $display("FAIL auto_wrap_count act=%0d exp=2", wraps);
        end
    endtask

    task automatic test_freeze_and_entry();
        logic [3:0] hy;
        logic [1:0] hch;
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if ({c_y, c_ych, c_vld, c_wrap} !== {e_y[2], 2'(e_ch[2]), e_vld[2], e_wrap[2]}) begin
                failures++; $display("FAIL pre_freeze act=%h exp=%h", {c_y, c_ych, c_vld, c_wrap},
                                     {e_y[2], 2'(e_ch[2]), e_vld[2], e_wrap[2]});
            end
        end
        hy = c_y; hch = c_ych;
        c_en = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            checks++;
            if ({c_y, c_ych, c_vld, c_wrap} !== {hy, hch, 2'b00}) begin
                failures++; $display("FAIL freeze act=%h exp=%h", {c_y, c_ych, c_vld, c_wrap}, {hy, hch, 2'b00});
            end
        end
        c_en = 1;
        tick();
        checks++;
        if ({c_y, c_ych, c_vld} !== {4'hB, 2'd1, 1'b1}) begin
            failures++; $display("FAIL resume act=%h exp=%h", {c_y, c_ych, c_vld}, {4'hB, 2'd1, 1'b1});
        end
        for (int n = 0; n < 6; n++) begin
            tick();
            checks++;
            if ({c_y, c_ych, c_vld, c_wrap} !== {e_y[2], 2'(e_ch[2]), e_vld[2], e_wrap[2]}) begin
                failures++; $display("FAIL post_resume act=%h exp=%h", {c_y, c_ych, c_vld, c_wrap},
                                     {e_y[2], 2'(e_ch[2]), e_vld[2], e_wrap[2]});
            end
        end
        c_auto = 0; c_s = 2'($urandom);
        tick();
        checks++;
        if ({c_y, c_ych, c_vld, c_wrap} !== {e_y[2], 2'(e_ch[2]), e_vld[2], e_wrap[2]}) begin
            failures++; $display("FAIL leave_auto act=%h exp=%h", {c_y, c_ych, c_vld, c_wrap},
                                 {e_y[2], 2'(e_ch[2]), e_vld[2], e_wrap[2]});
        end
        c_auto = 1;
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if ({c_y, c_ych, c_vld} !== {(n < 3) ? 4'hA : 4'hB, (n < 3) ? 2'd0 : 2'd1, 1'b1}) begin
                failures++; $display("FAIL reentry n=%0d act=%h", n, {c_y, c_ych, c_vld});
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        c_auto = 0;
        tick();
        c_auto = 1;
        repeat (7) tick();
        c_rst = 1;
        tick();
        checks++;
        if ({c_y, c_ych, c_vld, c_wrap} !== 8'h0) begin
            failures++; $display("FAIL mid_reset act=%h exp=0", {c_y, c_ych, c_vld, c_wrap});
        end
        c_rst = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if ({c_y, c_ych, c_vld, c_wrap} !== {(n < 3) ? 4'hA : 4'hB, (n < 3) ? 2'd0 : 2'd1, 2'b10}) begin
                failures++; $display("FAIL after_reset n=%0d act=%h", n, {c_y, c_ych, c_vld, c_wrap});
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            a_rst = ($urandom_range(0, 49) == 0); b_rst = ($urandom_range(0, 49) == 0);
            c_rst = ($urandom_range(0, 49) == 0);
            a_en = ($urandom_range(0, 4) != 0); b_en = ($urandom_range(0, 4) != 0);
            c_en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 19) == 0) a_auto = ~a_auto;
            if ($urandom_range(0, 19) == 0) b_auto = ~b_auto;
            if ($urandom_range(0, 19) == 0) c_auto = ~c_auto;
            a_s = 3'($urandom); b_s = 3'($urandom); c_s = 2'($urandom);
            a_i = $urandom; b_i = 24'($urandom); c_i = 16'($urandom);
            tick();
            checks++;
            if ({a_y, a_ych, a_vld, a_wrap} !== {e_y[0], 3'(e_ch[0]), e_vld[0], e_wrap[0]}) begin
                failures++; $display("FAIL rand_a n=%0d act=%h exp=%h", n, {a_y, a_ych, a_vld, a_wrap},
                                     {e_y[0], 3'(e_ch[0]), e_vld[0], e_wrap[0]});
            end
            checks++;
            if ({b_y, b_ych, b_vld, b_wrap} !== {e_y[1], 3'(e_ch[1]), e_vld[1], e_wrap[1]}) begin
                failures++; $display("FAIL rand_b n=%0d act=%h exp=%h", n, {b_y, b_ych, b_vld, b_wrap},
                                     {e_y[1], 3'(e_ch[1]), e_vld[1], e_wrap[1]});
            end
            checks++;
            if ({c_y, c_ych, c_vld, c_wrap} !== {e_y[2], 2'(e_ch[2]), e_vld[2], e_wrap[2]}) begin
                failures++; $display("FAIL rand_c n=%0d act=%h exp=%h", n, {c_y, c_ych, c_vld, c_wrap},
                                     {e_y[2], 2'(e_ch[2]), e_vld[2], e_wrap[2]});
            end
        end
    endtask

    initial begin
        a_rst = 1; a_en = 0; a_auto = 0; a_s = '0; a_i = '0;
        b_rst = 1; b_en = 0; b_auto = 0; b_s = '0; b_i = '0;
        c_rst = 1; c_en = 0; c_auto = 0; c_s = '0; c_i = '0;
        for (int n = 0; n < 3; n++) begin
            m_k[n] = 0; m_prev[n] = 1'b0; e_y[n] = 4'h0; e_ch[n] = 0; e_vld[n] = 1'b0; e_wrap[n] = 1'b0;
        end
        test_reset();
        test_manual();
        test_out_of_range();
        test_auto_scan();
        test_freeze_and_entry();
        test_reset_mid_scan();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scan_mux.md
# scan_mux

Registered, parametrised N:1 multiplexer for multi-bit channels. It has two modes. In manual mode a select input chooses the channel. In auto-scan mode an internal pointer steps through every channel in turn, holding each one for a programmable dwell time. It sits between a bank of parallel sources and a single serial consumer, for example a display driver, a UART front end or a debug probe. Every output is registered, tagged with its channel index and qualified by a valid flag.

## Interface
- CH, 8: number of input channels; CH ≥ 2, need not be a power of two
- DW, 4: data width per channel in bits
- DWELL, 1: cycles each channel is held in auto mode; DWELL ≥ 1
- SW, derived: select width, $clog2(CH); not overridable

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- i  input  CH*DW  packed channels; channel k occupies bits i[k*DW +: DW]
- s  input  SW  manual channel select; used only when auto=0
- auto  input  1  1 = auto-scan mode, 0 = manual mode
- en  input  1  enables sampling; 0 freezes the block
- y  output  DW  registered selected data
- y_ch  output  SW  channel index that y was taken from
- y_vld  output  1  y and y_ch are valid this cycle
- wrap  output  1  one-cycle pulse when the scan pointer wraps from CH-1 to 0

## Operation
- Reset, when rst is high at a clock edge: y=0, y_ch=0, y_vld=0, wrap=0, scan pointer ptr=0, dwell counter dcnt=0, auto_q=0. Reset takes priority over every other input. Reset mid-scan abandons the scan, and it restarts at channel 0.
- en=0: y, y_ch, ptr and dcnt hold their values. y_vld=0 and wrap=0 on the next edge.
- Manual mode (auto=0, en=1):
  - If s < CH: y <= channel s, y_ch <= s, y_vld <= 1.
  - If s ≥ CH (only possible when CH is not a power of two): y and y_ch hold, y_vld <= 0.
  - ptr and dcnt are unaffected.
- Auto mode (auto=1, en=1):
  - y <= channel ptr, y_ch <= ptr, y_vld <= 1. s is ignored.
  - dcnt increments each enabled cycle. When dcnt == DWELL-1: dcnt <= 0 and ptr advances.
  - ptr advances by one. From CH-1 it wraps to 0 and asserts wrap for one cycle. That wrap pulse is aligned with the output of channel CH-1's final dwell cycle.
- Mode entry: auto_q registers auto. A rising edge of auto (auto=1, auto_q=0) forces ptr=0 and dcnt=0 before sampling, so the first auto output is always channel 0.
  - Leaving auto mode does not clear ptr.
  - A mode change is evaluated in the same cycle it occurs, so the output in that cycle follows the new mode.
- DWELL=1: the channel changes every enabled cycle, and wrap pulses once every CH enabled cycles.
- Arithmetic: ptr is SW bits and never exceeds CH-1. dcnt is $clog2(DWELL+1) bits (minimum 1) and never exceeds DWELL-1.

## Timing
- Latency is one cycle. Inputs sampled at edge n appear on y, y_ch and y_vld after edge n, and stay until the next enabled edge.
- Auto-mode sequence: for the k-th enabled cycle after entry (k=0,1,…), y_ch = floor(k/DWELL) mod CH.
- A full scan takes CH*DWELL enabled cycles.
- With en=0, the scan stretches, it does not skip: the sequence resumes exactly where it paused.
- There are no combinational paths from inputs to outputs.
- Simultaneous rst and a rising edge of auto: reset wins, and auto_q is 0 after reset. If auto is still 1 on the next edge, that is treated as mode entry.

## Structure
- Shared package scan_pkg contains:
  - the SW derivation function (clog2 with a minimum of 1)
  - the dcnt width derivation
  - the mode encoding constants MODE_MANUAL=0 and MODE_AUTO=1
- One sub-module, scan_ctr: the ptr and dcnt counters with wrap generation. Its parameters are CH and DWELL. Its ports are clk, rst, en, restart, ptr, wrap.
- The top level holds the output registers and the channel-select slice.

## Test plan
- Reset: drive rst=1 for 2 cycles with random i, auto=1, en=1. Required: y=0, y_ch=0, y_vld=0, wrap=0 throughout.
- Manual select: CH=8, DW=4, i=32'h7654_3210, auto=0, en=1, s=5. One cycle later: y=4'h5, y_ch=5, y_vld=1.
- Out-of-range select: CH=6, s=6 and then s=7. Required: y_vld=0 and y holds its previous value.
- Auto scan: CH=4, DWELL=3, i=16'hDCBA. Required: y_ch runs 0,0,0,1,1,1,2,2,2,3,3,3,0,… with y matching (A,B,C,D). wrap pulses exactly once per 12 cycles, together with the last y_ch=3.
- Freeze and mode entry: en=0 for 5 cycles partway through a scan. Required: y_vld=0, then the sequence resumes where it paused. Then toggle auto 1→0→1. Required: the scan restarts at channel 0.
- Reset mid-scan: assert rst while ptr=2, dcnt=1. After release with auto=1: the first output is y_ch=0 and it is held for a full DWELL.
